// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Provides the default data width, the index of the hardwired-zero register,
// the default register-address type and a helper that derives a safe
// address width from a register count.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Index of the hardwired-zero register (x0).
  localparam int REG_ZERO = 0;

  // Address width for n registers; never below 1 so degenerate counts still
  // produce a legal vector width.
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [addr_w(NREGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, ALU and load write ports, load
// issue (scoreboard set) and the store-data valid/ready channel.
//   master : pipeline side (drives addresses, write data, requests)
//   slave  : register file side (returns read data, busy flags, store data)
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2
);
  localparam int AW = addr_w(NREGS);

  // read ports
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  // ALU writeback
  logic                     wa_en;
  logic [AW-1:0]            wa_addr;
  logic [XLEN-1:0]          wa_data;
  // load writeback
  logic                     wl_en;
  logic [AW-1:0]            wl_addr;
  logic [XLEN-1:0]          wl_data;
  // load issue
  logic                     ld_issue;
  logic [AW-1:0]            ld_rd;
  // store capture request
  logic                     st_req;
  logic [AW-1:0]            st_rs;
  logic                     st_req_ready;
  // store data to memory
  logic                     st_valid;
  logic [XLEN-1:0]          st_data;
  logic                     st_ready;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wl_en, wl_addr, wl_data,
           ld_issue, ld_rd, st_req, st_rs, st_ready,
    input  rd_data, rd_busy, st_req_ready, st_valid, st_data
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wl_en, wl_addr, wl_data,
           ld_issue, ld_rd, st_req, st_rs, st_ready,
    output rd_data, rd_busy, st_req_ready, st_valid, st_data
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   set_en, set_addr   load issued to set_addr (marks it pending)
//   clr_en, clr_addr   load writeback to clr_addr (clears pending)
//   pending            current pending vector, bit 0 always 0
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = addr_w(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] pending
);

  logic [NREGS-1:0] pending_nxt;

  // Set is evaluated after clear so a load issued in the same cycle as an
  // older load's writeback to the same register keeps the bit set.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NREGS; i++) begin
      if (clr_en && (clr_addr == AW'(i))) pending_nxt[i] = 1'b0;
      if (set_en && (set_addr == AW'(i))) pending_nxt[i] = 1'b1;
    end
    pending_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port core register file with load scoreboard and store-data buffer.
// NRD write-through read ports, ALU and load writeback ports (load wins on
// conflict), x0 hardwired to zero, per-register pending-load tracking and a
// one-entry valid/ready buffer carrying store data to data memory.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (clears registers, scoreboard,
//          store buffer)
//   bus    regfile_mp_if slave: read ports, write ports, load issue, store
//          request and store-data channel
module regfile_mp import regfile_pkg::*; #(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int AW = addr_w(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic             st_valid_q;
  logic [XLEN-1:0]  st_data_q;
  logic             st_req_ready;
  logic             st_accept;
  logic [XLEN-1:0]  st_fwd;

  // Write-through read value: x0 reads zero, then the load writeback, then
  // the ALU writeback, then the stored register contents.
  function automatic logic [XLEN-1:0] fwd_value(
    input logic [AW-1:0]   addr,
    input logic [XLEN-1:0] stored,
    input logic            wl_en,
    input logic [AW-1:0]   wl_addr,
    input logic [XLEN-1:0] wl_data,
    input logic            wa_en,
    input logic [AW-1:0]   wa_addr,
    input logic [XLEN-1:0] wa_data
  );
    logic [XLEN-1:0] v;
    if (addr == AW'(REG_ZERO))             v = '0;
    else if (wl_en && (wl_addr == addr))   v = wl_data;
    else if (wa_en && (wa_addr == addr))   v = wa_data;
    else                                   v = stored;
    return v;
  endfunction

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (bus.ld_issue),
    .set_addr (bus.ld_rd),
    .clr_en   (bus.wl_en),
    .clr_addr (bus.wl_addr),
    .pending  (pending)
  );

  // Read ports. A same-cycle load writeback to the source clears its busy
  // flag because the bypass already delivers the loaded value.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      bus.rd_data[i] = fwd_value(bus.rd_addr[i], regs[bus.rd_addr[i]],
                                 bus.wl_en, bus.wl_addr, bus.wl_data,
                                 bus.wa_en, bus.wa_addr, bus.wa_data);
      bus.rd_busy[i] = pending[bus.rd_addr[i]] &&
                       !(bus.wl_en && (bus.wl_addr == bus.rd_addr[i]));
    end
  end

  // Register array. The load write is issued last so it overrides an ALU
  // write to the same register in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      if (bus.wa_en && (bus.wa_addr != AW'(REG_ZERO)))
        regs[bus.wa_addr] <= bus.wa_data;
      if (bus.wl_en && (bus.wl_addr != AW'(REG_ZERO)))
        regs[bus.wl_addr] <= bus.wl_data;
    end
  end

  // Store buffer: a new capture is accepted whenever the slot is empty or
  // is being drained this cycle. Pending sources are not checked here; the
  // requester stalls through a read port.
  assign st_req_ready = !st_valid_q || bus.st_ready;
  assign st_accept    = bus.st_req && st_req_ready;
  assign st_fwd       = fwd_value(bus.st_rs, regs[bus.st_rs],
                                  bus.wl_en, bus.wl_addr, bus.wl_data,
                                  bus.wa_en, bus.wa_addr, bus.wa_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_valid_q <= 1'b0;
      st_data_q  <= '0;
    end else if (st_accept) begin
      st_valid_q <= 1'b1;
      st_data_q  <= st_fwd;
    end else if (bus.st_ready && st_valid_q) begin
      st_valid_q <= 1'b0;
    end
  end

  assign bus.st_req_ready = st_req_ready;
  assign bus.st_valid     = st_valid_q;
  assign bus.st_data      = st_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();
  regfile_mp_if #(.XLEN(32), .NREGS(16), .NRD(3)) bus2 ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: architectural state in plain arrays.
  logic [31:0] mregs [32];
  bit          mpend [32];
  bit          mvalid;
  logic [31:0] mdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (bus.wl_en && bus.wl_addr == a) return bus.wl_data;
    if (bus.wa_en && bus.wa_addr == a) return bus.wa_data;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    return mpend[a] && !(bus.wl_en && bus.wl_addr == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = 32'h0;
      mpend[i] = 1'b0;
    end
    mvalid = 1'b0;
    mdata  = 32'h0;
  endtask

  // Edge update from the inputs currently applied.
  task automatic model_edge();
    logic acc;
    logic [31:0] sv;
    acc = bus.st_req && (!mvalid || bus.st_ready);
    sv  = exp_rd(bus.st_rs);
    if (bus.wa_en && bus.wa_addr != 0) mregs[bus.wa_addr] = bus.wa_data;
    if (bus.wl_en && bus.wl_addr != 0) mregs[bus.wl_addr] = bus.wl_data;
    if (bus.wl_en) mpend[bus.wl_addr] = 1'b0;
    if (bus.ld_issue && bus.ld_rd != 0) mpend[bus.ld_rd] = 1'b1;
    if (acc) begin
      mvalid = 1'b1;
      mdata  = sv;
    end else if (bus.st_ready && mvalid) begin
      mvalid = 1'b0;
    end
  endtask

  task automatic idle();
    bus.rd_addr = '0;
    bus.wa_en = 0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wl_en = 0; bus.wl_addr = '0; bus.wl_data = '0;
    bus.ld_issue = 0; bus.ld_rd = '0;
    bus.st_req = 0; bus.st_rs = '0; bus.st_ready = 0;
  endtask

  task automatic idle2();
    bus2.rd_addr = '0;
    bus2.wa_en = 0; bus2.wa_addr = '0; bus2.wa_data = '0;
    bus2.wl_en = 0; bus2.wl_addr = '0; bus2.wl_data = '0;
    bus2.ld_issue = 0; bus2.ld_rd = '0;
    bus2.st_req = 0; bus2.st_rs = '0; bus2.st_ready = 0;
  endtask

  // Check combinational outputs, clock once, check registered outputs.
  task automatic tick();
    #1;
    chk("rd_data0", bus.rd_data[0], exp_rd(bus.rd_addr[0]));
    chk("rd_data1", bus.rd_data[1], exp_rd(bus.rd_addr[1]));
    chk("rd_busy0", 32'(bus.rd_busy[0]), 32'(exp_busy(bus.rd_addr[0])));
    chk("rd_busy1", 32'(bus.rd_busy[1]), 32'(exp_busy(bus.rd_addr[1])));
    chk("st_req_ready", 32'(bus.st_req_ready), 32'(!mvalid || bus.st_ready));
    @(posedge clk);
    model_edge();
    #1;
    chk("st_valid", 32'(bus.st_valid), 32'(mvalid));
    chk("st_data", bus.st_data, mdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle();
    idle2();
    model_reset();
    #2;
    // Outputs under reset, before any clock edge.
    chk("rst_rd0", bus.rd_data[0], 32'h0);
    chk("rst_busy", 32'(bus.rd_busy), 32'h0);
    chk("rst_st_valid", 32'(bus.st_valid), 32'h0);
    chk("rst_st_data", bus.st_data, 32'h0);
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;

    // Build up state, then reset mid-run.
    bus.wa_en = 1; bus.wa_addr = 5; bus.wa_data = 32'hCAFE0005;
    bus.ld_issue = 1; bus.ld_rd = 6;
    tick();
    idle();
    bus.st_req = 1; bus.st_rs = 5;
    tick();
    idle();
    bus.rd_addr[0] = 5; bus.rd_addr[1] = 6;
    #1;
    chk("pre_rst_rd0", bus.rd_data[0], 32'hCAFE0005);
    chk("pre_rst_busy1", 32'(bus.rd_busy[1]), 32'h1);
    chk("pre_rst_st_valid", 32'(bus.st_valid), 32'h1);
    #1 reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_rd0", bus.rd_data[0], 32'h0);
    chk("mid_rst_busy", 32'(bus.rd_busy), 32'h0);
    chk("mid_rst_st_valid", 32'(bus.st_valid), 32'h0);
    chk("mid_rst_st_data", bus.st_data, 32'h0);
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rd0", bus.rd_data[0], 32'h0);
    chk("post_rst_busy", 32'(bus.rd_busy), 32'h0);

    // Write x5 then read it.
    idle();
    bus.wa_en = 1; bus.wa_addr = 5; bus.wa_data = 32'h00000001;
    tick();
    idle();
    bus.rd_addr[0] = 5;
    #1 chk("x5_read", bus.rd_data[0], 32'h00000001);
    tick();

    // Same-cycle wa/wl to x3: load wins, both in bypass and in storage.
    bus.wa_en = 1; bus.wa_addr = 3; bus.wa_data = 32'h5;
    bus.wl_en = 1; bus.wl_addr = 3; bus.wl_data = 32'hA;
    bus.rd_addr[0] = 3;
    #1 chk("x3_bypass", bus.rd_data[0], 32'hA);
    tick();
    idle();
    bus.rd_addr[0] = 3;
    #1 chk("x3_stored", bus.rd_data[0], 32'hA);
    tick();

    // Writes to x0 are discarded.
    bus.wa_en = 1; bus.wa_addr = 0; bus.wa_data = 32'hFFFFFFFF;
    bus.wl_en = 1; bus.wl_addr = 0; bus.wl_data = 32'hFFFFFFFF;
    bus.rd_addr[0] = 0;
    #1 chk("x0_bypass", bus.rd_data[0], 32'h0);
    tick();
    idle();
    bus.rd_addr[0] = 0;
    #1 chk("x0_stored", bus.rd_data[0], 32'h0);
    tick();

    // Load scoreboard on x7.
    bus.ld_issue = 1; bus.ld_rd = 7;
    tick();
    idle();
    bus.rd_addr[0] = 7;
    #1 chk("x7_busy", 32'(bus.rd_busy[0]), 32'h1);
    tick();
    bus.rd_addr[0] = 7;
    bus.wl_en = 1; bus.wl_addr = 7; bus.wl_data = 32'h1234;
    #1;
    chk("x7_wb_busy", 32'(bus.rd_busy[0]), 32'h0);
    chk("x7_wb_data", bus.rd_data[0], 32'h1234);
    tick();
    idle();
    bus.rd_addr[0] = 7;
    #1 chk("x7_cleared", 32'(bus.rd_busy[0]), 32'h0);
    tick();

    // Set beats clear on x9.
    bus.ld_issue = 1; bus.ld_rd = 9;
    tick();
    bus.wl_en = 1; bus.wl_addr = 9; bus.wl_data = 32'h99;
    bus.rd_addr[1] = 9;
    tick();
    idle();
    bus.rd_addr[1] = 9;
    #1;
    chk("x9_data", bus.rd_data[1], 32'h99);
    chk("x9_still_busy", 32'(bus.rd_busy[1]), 32'h1);
    tick();

    // Store channel.
    bus.wa_en = 1; bus.wa_addr = 4; bus.wa_data = 32'hDEAD;
    tick();
    bus.wa_en = 1; bus.wa_addr = 5; bus.wa_data = 32'hBEEF;
    tick();
    idle();
    bus.st_req = 1; bus.st_rs = 4;
    tick();
    #1;
    chk("st1_valid", 32'(bus.st_valid), 32'h1);
    chk("st1_data", bus.st_data, 32'hDEAD);
    chk("st1_req_ready", 32'(bus.st_req_ready), 32'h0);
    bus.st_rs = 5;
    tick();
    chk("st2_ignored", bus.st_data, 32'hDEAD);
    bus.st_ready = 1;
    #1 chk("st3_req_ready", 32'(bus.st_req_ready), 32'h1);
    tick();
    chk("st3_valid", 32'(bus.st_valid), 32'h1);
    chk("st3_data", bus.st_data, 32'hBEEF);
    bus.st_req = 0;
    tick();
    chk("st4_valid", 32'(bus.st_valid), 32'h0);
    chk("st4_data_hold", bus.st_data, 32'hBEEF);
    idle();

    // NRD=3, NREGS=16 instance.
    bus2.wa_en = 1; bus2.wa_addr = 1; bus2.wa_data = 32'h11;
    @(posedge clk); #1;
    bus2.wa_en = 1; bus2.wa_addr = 15; bus2.wa_data = 32'h77;
    bus2.rd_addr[0] = 1; bus2.rd_addr[1] = 15; bus2.rd_addr[2] = 0;
    #1;
    chk("nrd3_x1", bus2.rd_data[0], 32'h11);
    chk("nrd3_x15", bus2.rd_data[1], 32'h77);
    chk("nrd3_x0", bus2.rd_data[2], 32'h0);
    @(posedge clk); #1;
    idle2();
    bus2.rd_addr[0] = 1; bus2.rd_addr[1] = 15; bus2.rd_addr[2] = 0;
    #1;
    chk("nrd3_x15_stored", bus2.rd_data[1], 32'h77);
    chk("nrd3_x0_stored", bus2.rd_data[2], 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bus.rd_addr[0] = 5'($urandom_range(0, 7));
      bus.rd_addr[1] = 5'($urandom_range(0, 7));
      bus.wa_en    = ($urandom_range(0, 2) == 0);
      bus.wa_addr  = 5'($urandom_range(0, 7));
      bus.wa_data  = $urandom;
      bus.wl_en    = ($urandom_range(0, 2) == 0);
      bus.wl_addr  = 5'($urandom_range(0, 7));
      bus.wl_data  = $urandom;
      bus.ld_issue = ($urandom_range(0, 2) == 0);
      bus.ld_rd    = 5'($urandom_range(0, 7));
      bus.st_req   = ($urandom_range(0, 1) == 0);
      bus.st_rs    = 5'($urandom_range(0, 7));
      bus.st_ready = ($urandom_range(0, 1) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
